// File: rtl/exu_dispatch_pkg.sv
// rtl/exu_dispatch_pkg.sv - shared widths, opcodes and FSM state type for the dispatch slice
package exu_dispatch_pkg;

    localparam int ALUOP_WIDTH = 4;
    localparam int BRSEL_WIDTH = 3;

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD = 4'd0;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB = 4'd1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WB    = 2'd2
    } disp_state_e;

    // Branch-type instructions write back the link address, everything else the ALU result.
    function automatic logic [63:0] wb_result(input logic [BRSEL_WIDTH-1:0] brsel,
                                              input logic [63:0]            pc,
                                              input logic [63:0]            alu_out);
        return (brsel != '0) ? pc + 64'd4 : alu_out;
    endfunction

endpackage

// File: rtl/exu_dispatch_watchdog.sv
// rtl/exu_dispatch_watchdog.sv - exu_watchdog: counts enabled cycles, flags the last allowed one
module exu_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic enable_i,
    input  logic clear_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry marks the TIMEOUT_CYCLES-th enabled cycle so the owner can leave on that edge.
    assign expired_o = enable_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/exu_dispatch.sv
// rtl/exu_dispatch.sv - single-issue dispatch between decode, execution unit and writeback
// Optional ISSUE watchdog enabled by defining EXU_DISPATCH_TIMEOUT_EN.
module exu_dispatch
    import exu_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [63:0]            in_a,
    input  logic [63:0]            in_b,
    input  logic [63:0]            in_pc,
    input  logic [63:0]            in_sext,
    input  logic [ALUOP_WIDTH-1:0] in_aluop,
    input  logic [BRSEL_WIDTH-1:0] in_brsel,
    input  logic [4:0]             in_rd,
    input  logic                   in_wen,
    output logic                   exu_valid,
    output logic [63:0]            exu_a,
    output logic [63:0]            exu_b,
    output logic [63:0]            exu_pc,
    output logic [63:0]            exu_sext,
    output logic [ALUOP_WIDTH-1:0] exu_aluop,
    output logic [BRSEL_WIDTH-1:0] exu_brsel,
    input  logic [63:0]            exu_alu_out,
    input  logic [63:0]            exu_br_out,
    input  logic                   exu_redirect,
    input  logic                   exu_finish,
    output logic                   wb_valid,
    input  logic                   wb_ready,
    output logic [63:0]            wb_data,
    output logic [4:0]             wb_rd,
    output logic                   wb_wen,
    output logic                   redirect_valid,
    output logic [63:0]            redirect_pc,
    output logic                   timeout_err
);

    disp_state_e state_q, state_d;

    logic [63:0]            a_q, b_q, pc_q, sext_q;
    logic [ALUOP_WIDTH-1:0] aluop_q;
    logic [BRSEL_WIDTH-1:0] brsel_q;
    logic [4:0]             rd_q;
    logic                   wen_q;
    logic [63:0]            wb_data_q;
    logic                   redir_q;
    logic [63:0]            redir_pc_q;

    logic accept;
    logic issue_done;
    logic wd_expired;

    // in_ready is gated by rst so it only rises once reset is released.
    assign in_ready   = (state_q == IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign issue_done = (state_q == ISSUE) && exu_finish;

`ifdef EXU_DISPATCH_TIMEOUT_EN
    logic timeout_q;

    exu_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .enable_i (state_q == ISSUE),
        .clear_i  (state_q != ISSUE),
        .expired_o(wd_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if ((state_q == ISSUE) && !exu_finish && wd_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_cfg;

    assign unused_cfg  = (TIMEOUT_CYCLES > 0);
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                // A finish landing on the expiry cycle still completes normally.
                if (exu_finish) begin
                    state_d = wen_q ? WB : IDLE;
                end else if (wd_expired) begin
                    state_d = IDLE;
                end
            end
            WB: begin
                if (wb_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            pc_q       <= '0;
            sext_q     <= '0;
            aluop_q    <= '0;
            brsel_q    <= '0;
            rd_q       <= '0;
            wen_q      <= 1'b0;
            wb_data_q  <= '0;
            redir_q    <= 1'b0;
            redir_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= in_a;
                b_q     <= in_b;
                pc_q    <= in_pc;
                sext_q  <= in_sext;
                aluop_q <= in_aluop;
                brsel_q <= in_brsel;
                rd_q    <= in_rd;
                wen_q   <= in_wen;
            end
            if (issue_done) begin
                wb_data_q <= wb_result(brsel_q, pc_q, exu_alu_out);
            end
            redir_q <= issue_done && exu_redirect;
            if (issue_done && exu_redirect) begin
                redir_pc_q <= exu_br_out;
            end
        end
    end

    assign exu_valid      = (state_q == ISSUE);
    assign exu_a          = a_q;
    assign exu_b          = b_q;
    assign exu_pc         = pc_q;
    assign exu_sext       = sext_q;
    assign exu_aluop      = aluop_q;
    assign exu_brsel      = brsel_q;
    assign wb_valid       = (state_q == WB);
    assign wb_data        = wb_data_q;
    assign wb_rd          = rd_q;
    assign wb_wen         = wen_q;
    assign redirect_valid = redir_q;
    assign redirect_pc    = redir_pc_q;

endmodule

// File: tb/tb_exu_dispatch.sv
// tb/tb_exu_dispatch.sv - randomized transaction-level bench for exu_dispatch
module tb_exu_dispatch;
    import exu_dispatch_pkg::*;

    localparam int TMO = 8;
    localparam int NT  = 24;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid, in_ready;
    logic [63:0]            in_a, in_b, in_pc, in_sext;
    logic [ALUOP_WIDTH-1:0] in_aluop;
    logic [BRSEL_WIDTH-1:0] in_brsel;
    logic [4:0]             in_rd;
    logic                   in_wen;
    logic                   exu_valid;
    logic [63:0]            exu_a, exu_b, exu_pc, exu_sext;
    logic [ALUOP_WIDTH-1:0] exu_aluop;
    logic [BRSEL_WIDTH-1:0] exu_brsel;
    logic [63:0]            exu_alu_out, exu_br_out;
    logic                   exu_redirect, exu_finish;
    logic                   wb_valid, wb_ready;
    logic [63:0]            wb_data;
    logic [4:0]             wb_rd;
    logic                   wb_wen;
    logic                   redirect_valid;
    logic [63:0]            redirect_pc;
    logic                   timeout_err;

    always #5 clk = ~clk;

    exu_dispatch #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_pc(in_pc), .in_sext(in_sext),
        .in_aluop(in_aluop), .in_brsel(in_brsel), .in_rd(in_rd), .in_wen(in_wen),
        .exu_valid(exu_valid), .exu_a(exu_a), .exu_b(exu_b), .exu_pc(exu_pc),
        .exu_sext(exu_sext), .exu_aluop(exu_aluop), .exu_brsel(exu_brsel),
        .exu_alu_out(exu_alu_out), .exu_br_out(exu_br_out),
        .exu_redirect(exu_redirect), .exu_finish(exu_finish),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data),
        .wb_rd(wb_rd), .wb_wen(wb_wen),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .timeout_err(timeout_err)
    );

    typedef struct {
        logic [63:0]            a, b, pc, sext;
        logic [ALUOP_WIDTH-1:0] aluop;
        logic [BRSEL_WIDTH-1:0] brsel;
        logic [4:0]             rd;
        logic                   wen;
        int                     delay;
        logic [63:0]            alu, br;
        logic                   redir;
        int                     stall;
        bit                     b2b;
        bit                     stray;
    } txn_t;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: redirect pulse owed in the next sampled cycle.
    logic        exp_rv  = 1'b0;
    logic [63:0] exp_rpc = '0;

    txn_t tl[NT];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.a     = {$urandom, $urandom};
        t.b     = {$urandom, $urandom};
        t.pc    = {$urandom, $urandom} & ~64'h3;
        t.sext  = {$urandom, $urandom};
        t.aluop = ALUOP_WIDTH'($urandom);
        t.brsel = ($urandom_range(0, 1) == 1) ? BRSEL_WIDTH'($urandom_range(1, 7)) : '0;
        t.rd    = 5'($urandom);
        t.wen   = ($urandom_range(0, 3) != 0);
        t.delay = $urandom_range(0, 4);
        t.alu   = {$urandom, $urandom};
        t.br    = {$urandom, $urandom};
        t.redir = ($urandom_range(0, 2) == 0);
        t.stall = $urandom_range(0, 3);
        t.b2b   = ($urandom_range(0, 1) == 1);
        t.stray = ($urandom_range(0, 1) == 1);
        return t;
    endfunction

    task automatic drive_in(input txn_t t, input logic v);
        in_valid = v;
        in_a     = t.a;
        in_b     = t.b;
        in_pc    = t.pc;
        in_sext  = t.sext;
        in_aluop = t.aluop;
        in_brsel = t.brsel;
        in_rd    = t.rd;
        in_wen   = t.wen;
    endtask

    // Sample the current IDLE cycle: owed redirect pulse, gap on exu_valid, ready high.
    task automatic idle_check();
        int w = 0;
        @(negedge clk);
        chk("redir_pulse", redirect_valid, exp_rv);
        if (exp_rv) chk("redir_pc", redirect_pc, exp_rpc);
        exp_rv = 1'b0;
        while (!in_ready && w < 20) begin
            cyc();
            @(negedge clk);
            w++;
        end
        chk("idle_in_ready", in_ready, 1);
        chk("idle_exu_gap", exu_valid, 0);
        chk("idle_wb_valid", wb_valid, 0);
    endtask

    task automatic run_txn(input txn_t t, input txn_t nx);
        logic [63:0] exp_wb;
        exu_finish   = 1'b0;
        exu_redirect = 1'b0;
        wb_ready     = 1'b0;
        drive_in(t, 1'b1);
        idle_check();
        cyc();
        if (t.b2b) drive_in(nx, 1'b1);
        else       drive_in(rand_txn(), 1'b0);
        for (int i = 0; i <= t.delay; i++) begin
            if (i == t.delay) begin
                exu_finish   = 1'b1;
                exu_alu_out  = t.alu;
                exu_br_out   = t.br;
                exu_redirect = t.redir;
            end
            @(negedge clk);
            chk("issue_valid", exu_valid, 1);
            chk("issue_a", exu_a, t.a);
            chk("issue_b", exu_b, t.b);
            chk("issue_pc", exu_pc, t.pc);
            chk("issue_sext", exu_sext, t.sext);
            chk("issue_ctl", {exu_aluop, exu_brsel}, {t.aluop, t.brsel});
            chk("issue_in_ready", in_ready, 0);
            chk("issue_wb_valid", wb_valid, 0);
            cyc();
        end
        exu_finish   = 1'b0;
        exu_redirect = 1'b0;
        exu_alu_out  = {$urandom, $urandom};
        exp_wb = (t.brsel != 0) ? t.pc + 64'd4 : t.alu;
        exp_rv = t.redir;
        if (t.redir) exp_rpc = t.br;
        if (t.wen) begin
            for (int s = 0; s <= t.stall; s++) begin
                wb_ready     = (s == t.stall);
                exu_finish   = t.stray && (s == 0);
                exu_redirect = exu_finish;
                @(negedge clk);
                chk("wb_valid", wb_valid, 1);
                chk("wb_data", wb_data, exp_wb);
                chk("wb_rd", wb_rd, t.rd);
                chk("wb_wen", wb_wen, 1);
                chk("wb_in_ready", in_ready, 0);
                chk("wb_exu_valid", exu_valid, 0);
                chk("wb_redir_pulse", redirect_valid, exp_rv);
                if (exp_rv) chk("wb_redir_pc", redirect_pc, exp_rpc);
                exp_rv = 1'b0;
                cyc();
            end
            wb_ready     = 1'b0;
            exu_finish   = 1'b0;
            exu_redirect = 1'b0;
        end
    endtask

    initial begin
        txn_t junk, tt;
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_pc = '0; in_sext = '0;
        in_aluop = '0; in_brsel = '0; in_rd = '0; in_wen = 1'b0;
        exu_alu_out = '0; exu_br_out = '0; exu_redirect = 1'b0; exu_finish = 1'b0;
        wb_ready = 1'b0;

        for (int i = 0; i < NT; i++) tl[i] = rand_txn();
        tl[0].a = 64'd5; tl[0].b = 64'd7; tl[0].aluop = ALUOP_ADD; tl[0].wen = 1'b1;
        tl[0].rd = 5'd3; tl[0].brsel = '0; tl[0].delay = 2; tl[0].alu = 64'd12;
        tl[0].redir = 1'b0; tl[0].b2b = 1'b1;
        tl[1].brsel = 3'd1; tl[1].pc = 64'h1000; tl[1].redir = 1'b1; tl[1].br = 64'h2000;
        tl[1].wen = 1'b1; tl[1].b2b = 1'b1;
        tl[2].wen = 1'b1; tl[2].stall = 5; tl[2].b2b = 1'b1;
        tl[3].brsel = 3'd2; tl[3].pc = 64'hFFFF_FFFF_FFFF_FFFC; tl[3].wen = 1'b0;
        tl[3].redir = 1'b1; tl[3].b2b = 1'b1;
        tl[4].delay = TMO - 1; tl[4].wen = 1'b1;
        tl[NT-1].b2b = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_exu_valid", exu_valid, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_redirect", redirect_valid, 0);
        chk("rst_timeout", timeout_err, 0);
        cyc();
        rst = 1'b0;

        for (int i = 0; i < NT; i++) begin
            run_txn(tl[i], (i + 1 < NT) ? tl[i + 1] : rand_txn());
        end

        junk = rand_txn();
        tt   = rand_txn();
        drive_in(tt, 1'b1);
        idle_check();
        cyc();
        drive_in(junk, 1'b0);
`ifdef EXU_DISPATCH_TIMEOUT_EN
        for (int i = 0; i < TMO; i++) begin
            @(negedge clk);
            chk("wd_issue_valid", exu_valid, 1);
            chk("wd_err_early", timeout_err, 0);
            cyc();
        end
        @(negedge clk);
        chk("wd_exu_valid", exu_valid, 0);
        chk("wd_in_ready", in_ready, 1);
        chk("wd_err", timeout_err, 1);
        chk("wd_no_wb", wb_valid, 0);
        chk("wd_no_redir", redirect_valid, 0);
        cyc();
        @(negedge clk);
        chk("wd_err_sticky", timeout_err, 1);
        chk("wd_no_wb_late", wb_valid, 0);
`else
        for (int i = 0; i < 3 * TMO; i++) cyc();
        @(negedge clk);
        chk("nowd_still_issue", exu_valid, 1);
        chk("nowd_err", timeout_err, 0);
        exu_finish = 1'b1;
        exu_redirect = 1'b0;
        cyc();
        exu_finish = 1'b0;
        @(negedge clk);
        chk("nowd_done_valid", exu_valid, tt.wen ? 1'b0 : 1'b0);
        chk("nowd_done_wb", wb_valid, tt.wen);
        wb_ready = 1'b1;
        cyc();
        wb_ready = 1'b0;
`endif

        tt = rand_txn();
        tt.wen = 1'b1;
        drive_in(tt, 1'b1);
        idle_check();
        cyc();
        drive_in(junk, 1'b0);
        cyc();
        rst = 1'b1;
        #1;
        chk("mid_rst_exu_valid", exu_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_exu_a", exu_a, 0);
        chk("mid_rst_wb_data", wb_data, 0);
        chk("mid_rst_timeout", timeout_err, 0);
        cyc();
        rst = 1'b0;
        exu_finish = 1'b1;
        exu_redirect = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        cyc();
        exu_finish = 1'b0;
        exu_redirect = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_no_wb", wb_valid, 0);
            chk("post_rst_no_redir", redirect_valid, 0);
            chk("post_rst_idle", exu_valid, 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/exu_dispatch.md
EXU_DISPATCH -- requirements
Module: exu_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, which is the maximum number of cycles spent waiting for exu_finish.
REQ-002 SHALL have port clk, input, 1 bit: the clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): the decode-side handshake.
REQ-005 SHALL have input ports in_a, in_b, in_pc and in_sext, each 64 bits: operands, PC and sign-extended immediate.
REQ-006 SHALL have input ports in_aluop (ALUOP_WIDTH), in_brsel (BRSEL_WIDTH), in_rd (5) and in_wen (1).
REQ-007 SHALL have output ports exu_valid (1), exu_a, exu_b, exu_pc and exu_sext (64 each), exu_aluop and exu_brsel: the execution-unit request.
REQ-008 SHALL have input ports exu_alu_out (64), exu_br_out (64), exu_redirect (1) and exu_finish (1): the execution-unit response.
REQ-009 SHALL have ports wb_valid (output, 1), wb_ready (input, 1), wb_data (output, 64), wb_rd (output, 5) and wb_wen (output, 1).
REQ-010 SHALL have output ports redirect_valid (1) and redirect_pc (64).
REQ-011 SHALL have output port timeout_err, 1 bit: sticky watchdog error.

Function
REQ-012 SHALL implement FSM states IDLE, ISSUE and WB.
REQ-013 SHALL drive in_ready=1 only in IDLE; on in_valid&&in_ready, latch all in_* fields and go to ISSUE on the next edge.
REQ-014 SHALL hold exu_valid=1 and the latched exu_* fields stable throughout ISSUE, and drive exu_valid=0 in IDLE and WB.
REQ-015 SHALL guarantee exu_valid is low for at least one cycle between consecutive requests, because the execution unit triggers on the rising edge.
REQ-016 SHALL, on exu_finish=1 in ISSUE: latch wb_data (in_brsel!=0 ? in_pc+4 : exu_alu_out, 64-bit wrap), then go to WB if in_wen=1, else to IDLE.
REQ-017 SHALL, on exu_finish in ISSUE with exu_redirect=1, pulse redirect_valid=1 for exactly one cycle, the cycle after finish, with redirect_pc=exu_br_out.
REQ-018 SHALL, in WB, hold wb_valid=1 and wb_data/wb_rd/wb_wen stable until wb_ready=1, then go to IDLE.
REQ-019 SHALL ignore exu_finish in IDLE or WB (stray pulses).
REQ-020 SHALL accept at most one instruction in flight; in_valid while busy is back-pressured, never dropped.

Reset
REQ-021 SHALL force state IDLE on rst asserted at any time, including mid-ISSUE or mid-WB, discarding the in-flight instruction.
REQ-022 SHALL reset all outputs to 0, except in_ready, which becomes 1 after reset deasserts.

Configuration
REQ-023 SHALL compile the watchdog only when EXU_DISPATCH_TIMEOUT_EN is defined.
REQ-024 SHALL, with the watchdog, count ISSUE cycles; on reaching TIMEOUT_CYCLES without finish, set timeout_err (sticky until rst), go to IDLE, and produce no writeback or redirect.
REQ-025 SHALL give exu_finish priority when it arrives in the same cycle as expiry.
REQ-026 SHALL, without the macro, wait in ISSUE indefinitely, with timeout_err tied to 0.

Structure
REQ-027 SHALL take ALUOP_WIDTH, BRSEL_WIDTH and the FSM state enum from the shared param package.
REQ-028 SHALL place the watchdog in sub-module exu_watchdog (enable, clear, expired).

Verification
REQ-029 SHALL cover: in_a=5, in_b=7, aluop=ADD, in_wen=1, rd=3; finish 2 cycles later with alu_out=12 -> wb_valid, wb_data=12, wb_rd=3.
REQ-030 SHALL cover: brsel!=0, pc=0x1000, finish with redirect=1, br_out=0x2000 -> one-cycle redirect_valid, redirect_pc=0x2000, wb_data=0x1004.
REQ-031 SHALL cover: back-to-back in_valid -> second accepted only after IDLE, with a ≥1-cycle exu_valid low gap.
REQ-032 SHALL cover: wb_ready held 0 for 5 cycles -> wb fields stable and in_ready=0 throughout.
REQ-033 SHALL cover: rst asserted mid-ISSUE -> outputs 0 immediately and no writeback afterward.
REQ-034 SHALL cover, with the macro and TIMEOUT_CYCLES=8: no finish -> timeout_err=1 after 8 cycles and return to IDLE.
